interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Collects up to NUM_SOURCES external interrupt lines and latches rising edges as pending.
//  Picks one eligible source by fixed priority and runs one complete interrupt cycle with the
//  register stacking unit: stack request, vector redirect, service, unstack request. Sits between
//  the peripheral IRQ lines and the stacking unit / fetch stage. One interrupt level only; no nesting.
// PARAMETERS
//  NUM_SOURCES   8                       number of IRQ inputs (2..32)
//  VECTOR_BASE   64'h0000_0000_0000_0100 address of vector 0
//  VECTOR_SHIFT  4                       vector stride = 1<<VECTOR_SHIFT bytes
// PORTS
//  clk_in                       in   1            single clock; everything on rising edge
//  rst_in                       in   1            asynchronous, active-high reset
//  irq_in                       in   NUM_SOURCES  peripheral interrupt lines, edge-sensitive
//  enable_in                    in   1            global interrupt enable
//  mask_wr_in                   in   1            load mask register from mask_data_in
//  mask_data_in                 in   NUM_SOURCES  1 = source enabled
//  mret_in                      in   1            1-cycle pulse: return-from-interrupt retired
//  stack_busy_in                in   1            stacking unit is saving registers
//  unstack_done_in              in   1            1-cycle pulse: stacking unit finished restoring
//  interrupt_signal_out         out  1            1-cycle stack request to the stacking unit
//  return_interrupt_signal_out  out  1            level unstack request, held until done
//  pc_redirect_out              out  1            1-cycle pulse: fetch must load vector_address_out
//  vector_address_out           out  64           VECTOR_BASE + (active_id_out << VECTOR_SHIFT)
//  active_id_out                out  ID_W         index of source in service; ID_W=$clog2(NUM_SOURCES)
//  pending_out                  out  NUM_SOURCES  pending register
//  in_service_out               out  1            high from STACK entry until UNSTACK completes
// BEHAVIOUR
//  Reset: state IDLE; pending=0; mask=0; irq_prev=0; all outputs 0; vector_address_out=VECTOR_BASE.
//  Edge detect: pending[i] set when irq_in[i]=1 and irq_prev[i]=0. A set and a clear of the same
//   bit in one cycle: set wins, so the bit stays pending. Masked sources still latch pending.
//  eligible = pending & mask. winner = lowest set index of eligible.
//  FSM:
//   IDLE    : if enable_in and |eligible -> STACK. Latch winner into active_id_out and
//             clear pending[winner]. interrupt_signal_out=1 in the first STACK cycle only.
//   STACK   : set seen_busy when stack_busy_in=1. When seen_busy and stack_busy_in=0 -> SERVICE,
//             and pulse pc_redirect_out for 1 cycle.
//   SERVICE : wait. On mret_in -> UNSTACK with return_interrupt_signal_out=1 from the next cycle.
//   UNSTACK : hold return_interrupt_signal_out=1. On unstack_done_in: drop it, -> IDLE.
//             in_service_out falls in the same cycle.
//  Latency: IRQ edge -> interrupt_signal_out = 2 cycles (edge register + IDLE decision).
//  mret_in outside SERVICE: ignored.
//  unstack_done_in outside UNSTACK: ignored.
//  enable_in=0 or a mask write: affects new selections only; the interrupt in service runs to completion.
//  mask_wr_in takes effect the next cycle; it is never blocked.
//  active_id_out and vector_address_out are registered and stable from STACK until return to IDLE.
//  The earliest next selection is in the first IDLE cycle after UNSTACK (back-to-back is allowed).
//  Reset mid-operation returns to IDLE immediately. No stack or unstack request is emitted on reset exit.
// STRUCTURE
//  Shared package: 2-bit state encoding (IDLE=0, STACK=1, SERVICE=2, UNSTACK=3),
//   VECTOR_BASE/VECTOR_SHIFT defaults.
//  Sub-module priority_encoder (NUM_SOURCES -> ID_W index + valid, lowest index wins), combinational.
//   It replaces any if/else chain.
//  Top: edge-detect register, pending and mask registers, FSM, output registers.
// TESTING
//  1 Reset, mask=8'hFF, enable=1, irq_in[3] rises
//    -> interrupt_signal_out pulse 2 cycles later; active_id_out=3.
//  2 Test 1 continued: stack_busy_in high 4 cycles then low
//    -> pc_redirect_out 1 pulse; vector_address_out=64'h130.
//  3 irq_in[5] and irq_in[2] rise together
//    -> id 2 serviced first. After mret_in and unstack_done_in, id 5 is serviced;
//       pending_out goes 8'h24 -> 8'h20 -> 8'h00.
//  4 mask=8'h00, irq_in[1] rises
//    -> pending_out=8'h02, no request. Mask write 8'h02 -> request; active_id_out=1.
//  5 mret_in pulsed in IDLE and in STACK
//    -> no return_interrupt_signal_out. In SERVICE it asserts the next cycle and holds
//       until unstack_done_in.
//  6 rst_in asserted in UNSTACK
//    -> all outputs 0 asynchronously; pending 0; IDLE with no spurious pulse after release.

Source files
------------

// File: rtl/interrupt_sequencer_pkg.sv
// rtl/interrupt_sequencer_pkg.sv - shared state encoding, vector defaults and vector helper
package interrupt_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STACK   = 2'd1,
    ST_SERVICE = 2'd2,
    ST_UNSTACK = 2'd3
  } state_e;

  localparam logic [63:0] DEFAULT_VECTOR_BASE  = 64'h0000_0000_0000_0100;
  localparam int unsigned DEFAULT_VECTOR_SHIFT = 4;

  function automatic logic [63:0] vector_of(input logic [63:0] base,
                                            input int unsigned shift,
                                            input logic [31:0] id);
    return base + (64'(id) << shift);
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// rtl/interrupt_sequencer_if.sv - IRQ, mask, stacking-unit and fetch redirect signal bundle
interface interrupt_sequencer_if #(
  parameter int NUM_SOURCES = 8
);
  localparam int ID_W = $clog2(NUM_SOURCES);

  logic [NUM_SOURCES-1:0] irq_in;
  logic                   enable_in;
  logic                   mask_wr_in;
  logic [NUM_SOURCES-1:0] mask_data_in;
  logic                   mret_in;
  logic                   stack_busy_in;
  logic                   unstack_done_in;
  logic                   interrupt_signal_out;
  logic                   return_interrupt_signal_out;
  logic                   pc_redirect_out;
  logic [63:0]            vector_address_out;
  logic [ID_W-1:0]        active_id_out;
  logic [NUM_SOURCES-1:0] pending_out;
  logic                   in_service_out;

  modport slave (
    input  irq_in, enable_in, mask_wr_in, mask_data_in, mret_in, stack_busy_in, unstack_done_in,
    output interrupt_signal_out, return_interrupt_signal_out, pc_redirect_out,
           vector_address_out, active_id_out, pending_out, in_service_out
  );

  modport master (
    output irq_in, enable_in, mask_wr_in, mask_data_in, mret_in, stack_busy_in, unstack_done_in,
    input  interrupt_signal_out, return_interrupt_signal_out, pc_redirect_out,
           vector_address_out, active_id_out, pending_out, in_service_out
  );

endinterface

// File: rtl/interrupt_sequencer_priority_encoder.sv
// rtl/interrupt_sequencer_priority_encoder.sv - lowest-index-wins encoder, combinational
module interrupt_sequencer_priority_encoder #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);
  localparam int W = $clog2(N);

  logic [N-1:0] lowest;

  // Isolate the lowest set bit, then OR its index together: one-hot, so no priority chain.
  always_comb begin
    lowest = req_i & (~req_i + N'(1));
    idx_o  = '0;
    for (int i = 0; i < N; i++) begin
      if (lowest[i]) begin
        idx_o = idx_o | W'(i);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - pending/mask capture and one-level interrupt stack/service/unstack sequencing
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int          NUM_SOURCES  = 8,
  parameter logic [63:0] VECTOR_BASE  = DEFAULT_VECTOR_BASE,
  parameter int unsigned VECTOR_SHIFT = DEFAULT_VECTOR_SHIFT
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  interrupt_sequencer_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_SOURCES);

  state_e                 state_q, state_d;
  logic [NUM_SOURCES-1:0] irq_prev_q;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] mask_q;
  logic                   seen_busy_q, seen_busy_d;
  logic [ID_W-1:0]        active_id_q, active_id_d;
  logic [63:0]            vector_q, vector_d;
  logic                   int_sig_q, int_sig_d;
  logic                   ret_sig_q, ret_sig_d;
  logic                   redirect_q, redirect_d;
  logic                   in_service_q, in_service_d;

  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] edge_set;
  logic [NUM_SOURCES-1:0] take_clr;
  logic [ID_W-1:0]        enc_idx;
  logic                   enc_valid;
  logic                   take;

  assign eligible = pending_q & mask_q;
  assign edge_set = bus.irq_in & ~irq_prev_q;

  interrupt_sequencer_priority_encoder #(
    .N (NUM_SOURCES)
  ) u_prio (
    .req_i   (eligible),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    state_d      = state_q;
    seen_busy_d  = seen_busy_q;
    active_id_d  = active_id_q;
    vector_d     = vector_q;
    int_sig_d    = 1'b0;
    redirect_d   = 1'b0;
    ret_sig_d    = ret_sig_q;
    in_service_d = in_service_q;
    take         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable_in && enc_valid) begin
          take         = 1'b1;
          state_d      = ST_STACK;
          active_id_d  = enc_idx;
          vector_d     = vector_of(VECTOR_BASE, VECTOR_SHIFT, 32'(enc_idx));
          int_sig_d    = 1'b1;
          in_service_d = 1'b1;
          seen_busy_d  = 1'b0;
        end
      end
      ST_STACK: begin
        // Busy must be observed high before its fall counts as "registers saved".
        if (seen_busy_q && !bus.stack_busy_in) begin
          state_d    = ST_SERVICE;
          redirect_d = 1'b1;
        end else if (bus.stack_busy_in) begin
          seen_busy_d = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (bus.mret_in) begin
          state_d   = ST_UNSTACK;
          ret_sig_d = 1'b1;
        end
      end
      ST_UNSTACK: begin
        if (bus.unstack_done_in) begin
          state_d      = ST_IDLE;
          ret_sig_d    = 1'b0;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    take_clr  = take ? (NUM_SOURCES'(1) << enc_idx) : '0;
    // New edges are OR-ed in last so a simultaneous set beats the clear.
    pending_d = (pending_q & ~take_clr) | edge_set;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      seen_busy_q  <= 1'b0;
      active_id_q  <= '0;
      vector_q     <= VECTOR_BASE;
      int_sig_q    <= 1'b0;
      ret_sig_q    <= 1'b0;
      redirect_q   <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= bus.irq_in;
      pending_q    <= pending_d;
      if (bus.mask_wr_in) begin
        mask_q <= bus.mask_data_in;
      end
      seen_busy_q  <= seen_busy_d;
      active_id_q  <= active_id_d;
      vector_q     <= vector_d;
      int_sig_q    <= int_sig_d;
      ret_sig_q    <= ret_sig_d;
      redirect_q   <= redirect_d;
      in_service_q <= in_service_d;
    end
  end

  assign bus.interrupt_signal_out        = int_sig_q;
  assign bus.return_interrupt_signal_out = ret_sig_q;
  assign bus.pc_redirect_out             = redirect_q;
  assign bus.vector_address_out          = vector_q;
  assign bus.active_id_out               = active_id_q;
  assign bus.pending_out                 = pending_q;
  assign bus.in_service_out              = in_service_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - directed bench with a cycle-level reference model of the sequencer
module tb_interrupt_sequencer;

  logic clk = 1'b0;
  logic rst;

  interrupt_sequencer_if #(.NUM_SOURCES(8)) bus ();

  interrupt_sequencer #(
    .NUM_SOURCES  (8),
    .VECTOR_BASE  (64'h100),
    .VECTOR_SHIFT (4)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases of one interrupt's life
  localparam int M_WAIT = 0, M_SAVE = 1, M_RUN = 2, M_RESTORE = 3;
  int          m_phase = M_WAIT;
  bit [7:0]    m_pend  = '0;
  bit [7:0]    m_mask  = '0;
  bit [7:0]    m_prev  = '0;
  bit          m_seen  = 1'b0;
  int          m_id    = 0;
  bit          e_int   = 1'b0;
  bit          e_redir = 1'b0;
  bit [63:0]   e_vec   = 64'h100;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = M_WAIT; m_pend = '0; m_mask = '0; m_prev = '0; m_seen = 1'b0;
      m_id = 0; e_int = 1'b0; e_redir = 1'b0; e_vec = 64'h100;
    end else begin
      bit [7:0] elig;
      elig    = m_pend & m_mask;
      e_int   = 1'b0;
      e_redir = 1'b0;
      if (m_phase == M_WAIT) begin
        if (bus.enable_in && elig != 0) begin
          for (int i = 0; i < 8; i++) begin
            if (elig[i]) begin
              m_id = i;
              break;
            end
          end
          m_pend[m_id] = 1'b0;
          e_vec   = 64'h100 + 64'(m_id) * 16;
          e_int   = 1'b1;
          m_seen  = 1'b0;
          m_phase = M_SAVE;
        end
      end else if (m_phase == M_SAVE) begin
        if (m_seen && !bus.stack_busy_in) begin
          m_phase = M_RUN;
          e_redir = 1'b1;
        end else if (bus.stack_busy_in) begin
          m_seen = 1'b1;
        end
      end else if (m_phase == M_RUN) begin
        if (bus.mret_in) m_phase = M_RESTORE;
      end else begin
        if (bus.unstack_done_in) m_phase = M_WAIT;
      end
      m_pend = m_pend | (bus.irq_in & ~m_prev);
      m_prev = bus.irq_in;
      if (bus.mask_wr_in) m_mask = bus.mask_data_in;
    end
  end

  always @(negedge clk) begin
    chk("int_sig",    64'(bus.interrupt_signal_out),        64'(e_int));
    chk("ret_sig",    64'(bus.return_interrupt_signal_out), 64'(m_phase == M_RESTORE));
    chk("redirect",   64'(bus.pc_redirect_out),             64'(e_redir));
    chk("active_id",  64'(bus.active_id_out),               64'(m_id));
    chk("vector",     bus.vector_address_out,               e_vec);
    chk("pending",    64'(bus.pending_out),                 64'(m_pend));
    chk("in_service", 64'(bus.in_service_out),              64'(m_phase != M_WAIT));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_stack(input int nbusy);
    bus.stack_busy_in = 1'b1;
    repeat (nbusy) tick();
    bus.stack_busy_in = 1'b0;
    tick();
  endtask

  task automatic finish_isr();
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    chk("lit_ret_up", 64'(bus.return_interrupt_signal_out), 64'd1);
    tick();
    bus.unstack_done_in = 1'b1;
    tick();
    bus.unstack_done_in = 1'b0;
    chk("lit_ret_down", 64'(bus.return_interrupt_signal_out), 64'd0);
    chk("lit_insvc_down", 64'(bus.in_service_out), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.irq_in = '0; bus.enable_in = 1'b0; bus.mask_wr_in = 1'b0; bus.mask_data_in = '0;
    bus.mret_in = 1'b0; bus.stack_busy_in = 1'b0; bus.unstack_done_in = 1'b0;
    tick(); tick();
    chk("lit_rst_pending", 64'(bus.pending_out), 64'h0);
    chk("lit_rst_vector", bus.vector_address_out, 64'h100);
    chk("lit_rst_int", 64'(bus.interrupt_signal_out), 64'd0);
    chk("lit_rst_insvc", 64'(bus.in_service_out), 64'd0);
    rst = 1'b0;
    tick();

    // 1/2: single source, latency and vector
    bus.mask_wr_in = 1'b1; bus.mask_data_in = 8'hFF; bus.enable_in = 1'b1;
    tick();
    bus.mask_wr_in = 1'b0; bus.irq_in = 8'h08;
    tick();
    chk("lit_t1_pending", 64'(bus.pending_out), 64'h08);
    chk("lit_t1_noint", 64'(bus.interrupt_signal_out), 64'd0);
    tick();
    chk("lit_t1_int", 64'(bus.interrupt_signal_out), 64'd1);
    chk("lit_t1_id", 64'(bus.active_id_out), 64'd3);
    run_stack(4);
    chk("lit_t2_redirect", 64'(bus.pc_redirect_out), 64'd1);
    chk("lit_t2_vector", bus.vector_address_out, 64'h130);
    tick();
    chk("lit_t2_redirect_end", 64'(bus.pc_redirect_out), 64'd0);
    finish_isr();
    bus.irq_in = 8'h00;
    tick();

    // 3: simultaneous edges, lowest index first, back-to-back
    bus.irq_in = 8'h24;
    tick();
    chk("lit_t3_pend24", 64'(bus.pending_out), 64'h24);
    tick();
    chk("lit_t3_pend20", 64'(bus.pending_out), 64'h20);
    chk("lit_t3_id2", 64'(bus.active_id_out), 64'd2);
    run_stack(2);
    finish_isr();
    chk("lit_t3_still20", 64'(bus.pending_out), 64'h20);
    tick();
    chk("lit_t3_int5", 64'(bus.interrupt_signal_out), 64'd1);
    chk("lit_t3_id5", 64'(bus.active_id_out), 64'd5);
    chk("lit_t3_pend00", 64'(bus.pending_out), 64'h00);
    chk("lit_t3_vec5", bus.vector_address_out, 64'h150);
    run_stack(1);
    finish_isr();
    bus.irq_in = 8'h00;

    // 4: masked source stays pending until the mask opens
    bus.mask_wr_in = 1'b1; bus.mask_data_in = 8'h00;
    tick();
    bus.mask_wr_in = 1'b0; bus.irq_in = 8'h02;
    tick(); tick(); tick();
    chk("lit_t4_pend02", 64'(bus.pending_out), 64'h02);
    chk("lit_t4_noreq", 64'(bus.in_service_out), 64'd0);
    bus.mask_wr_in = 1'b1; bus.mask_data_in = 8'h02;
    tick();
    bus.mask_wr_in = 1'b0;
    chk("lit_t4_notyet", 64'(bus.interrupt_signal_out), 64'd0);
    tick();
    chk("lit_t4_int", 64'(bus.interrupt_signal_out), 64'd1);
    chk("lit_t4_id1", 64'(bus.active_id_out), 64'd1);
    run_stack(1);
    finish_isr();

    // 5: mret and unstack_done outside their phases are ignored
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    tick();
    chk("lit_t5_idle_mret", 64'(bus.return_interrupt_signal_out), 64'd0);
    bus.mask_wr_in = 1'b1; bus.mask_data_in = 8'hFF;
    tick();
    bus.mask_wr_in = 1'b0; bus.irq_in = 8'h42;
    tick(); tick();
    chk("lit_t5_id6", 64'(bus.active_id_out), 64'd6);
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    chk("lit_t5_stack_mret", 64'(bus.return_interrupt_signal_out), 64'd0);
    run_stack(2);
    bus.unstack_done_in = 1'b1;
    tick();
    bus.unstack_done_in = 1'b0;
    chk("lit_t5_done_ignored", 64'(bus.in_service_out), 64'd1);
    tick();
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    chk("lit_t5_ret", 64'(bus.return_interrupt_signal_out), 64'd1);
    tick(); tick();
    chk("lit_t5_ret_hold", 64'(bus.return_interrupt_signal_out), 64'd1);
    bus.unstack_done_in = 1'b1;
    tick();
    bus.unstack_done_in = 1'b0;
    chk("lit_t5_ret_drop", 64'(bus.return_interrupt_signal_out), 64'd0);

    // 6: asynchronous reset while unstacking
    bus.irq_in = 8'h43;
    tick(); tick();
    chk("lit_t6_id0", 64'(bus.active_id_out), 64'd0);
    chk("lit_t6_vec0", bus.vector_address_out, 64'h100);
    run_stack(1);
    bus.mret_in = 1'b1;
    tick();
    bus.mret_in = 1'b0;
    bus.irq_in = 8'h53;
    tick();
    chk("lit_t6_pend10", 64'(bus.pending_out), 64'h10);
    chk("lit_t6_ret", 64'(bus.return_interrupt_signal_out), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("lit_t6_async_ret", 64'(bus.return_interrupt_signal_out), 64'd0);
    chk("lit_t6_async_insvc", 64'(bus.in_service_out), 64'd0);
    chk("lit_t6_async_pend", 64'(bus.pending_out), 64'h0);
    bus.irq_in = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("lit_t6_no_int", 64'(bus.interrupt_signal_out), 64'd0);
    chk("lit_t6_no_ret", 64'(bus.return_interrupt_signal_out), 64'd0);
    chk("lit_t6_idle", 64'(bus.in_service_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
